// File: rtl/mips32_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_fetch_queue_if
//  Purpose  : Instruction-memory, redirect/halt and decode handshake bundle
//             for the MIPS32 fetch queue.
//  Revision : 1.0
// ============================================================================
interface mips32_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 9
) ();
    localparam int c_cw = $clog2(DEPTH + 1);

    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            halt;
    logic            id_valid;
    logic [31:0]     id_ir;
    logic [31:0]     id_npc;
    logic            id_ready;
    logic [31:0]     pc_out;
    logic [c_cw-1:0] q_count;

    // Fetch block side
    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc, halt,
        output id_valid, id_ir, id_npc,
        input  id_ready,
        output pc_out, q_count
    );

    // Memory / decode / control side
    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc, halt,
        input  id_valid, id_ir, id_npc,
        output id_ready,
        input  pc_out, q_count
    );
endinterface
`default_nettype wire

// File: rtl/mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_fetch_queue
//  Purpose  : MIPS32 fetch front end: owns the PC, reads a synchronous imem
//             and buffers {ir, npc} in a FIFO presented to decode.
//  Revision : 1.0
// ============================================================================
module mips32_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 9
) (
    input  wire logic               clk1,
    input  wire logic               rst,
    mips32_fetch_queue_if.master    bus
);
    localparam int         c_cw       = $clog2(DEPTH + 1);
    localparam int         c_pw       = $clog2(DEPTH);
    localparam logic [5:0] c_hlt_op   = 6'b111111;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [c_cw-1:0] count_q, count_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_addr_q, inflight_addr_d;
    logic            hlt_seen_q, hlt_seen_d;

    logic [31:0]     ir_q  [DEPTH];
    logic [31:0]     npc_q [DEPTH];

    logic            w_redirect;
    logic [c_cw:0]   w_eff_occ;
    logic            w_issue;
    logic [31:0]     w_issue_addr;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    assign w_redirect = bus.redirect_valid;

    // A redirect discards both the queue and the outstanding read, so the
    // issue decision sees an empty pipe; a same-cycle pop frees nothing.
    always_comb begin
        w_eff_occ = '0;
        if (!w_redirect) begin
            w_eff_occ = {1'b0, count_q} + {{c_cw{1'b0}}, inflight_q};
        end
    end

    assign w_issue      = !rst && !bus.halt && (w_redirect || !hlt_seen_q)
                          && (w_eff_occ < c_depth);
    assign w_issue_addr = w_redirect ? bus.redirect_pc : pc_q;

    // The word trailing an HLT is still returned by memory; drop it here.
    assign w_push  = !rst && inflight_q && !w_redirect && !hlt_seen_q;
    assign w_valid = !rst && (count_q != '0) && !bus.halt;
    assign w_pop   = w_valid && bus.id_ready;

    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = rst ? '0 : w_issue_addr[AW-1:0];
    assign bus.id_valid  = w_valid;
    assign bus.id_ir     = ir_q[rd_ptr_q];
    assign bus.id_npc    = npc_q[rd_ptr_q];
    assign bus.pc_out    = pc_q;
    assign bus.q_count   = count_q;

    always_comb begin
        pc_d            = pc_q;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        hlt_seen_d      = hlt_seen_q;

        if (w_redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            hlt_seen_d = 1'b0;
            pc_d       = bus.redirect_pc;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_pw'(1);
                if (bus.imem_rdata[31:26] == c_hlt_op) begin
                    hlt_seen_d = 1'b1;
                end
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_pw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cw'(1);
                2'b01:   count_d = count_q - c_cw'(1);
                default: count_d = count_q;
            endcase
        end

        if (w_issue) begin
            pc_d            = w_issue_addr + 32'd1;
            inflight_d      = 1'b1;
            inflight_addr_d = w_issue_addr;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q            <= '0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            hlt_seen_q      <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            hlt_seen_q      <= hlt_seen_d;
        end
    end

    // Payload storage needs no reset: entries are only read behind count.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            ir_q[wr_ptr_q]  <= bus.imem_rdata;
            npc_q[wr_ptr_q] <= inflight_addr_q + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips32_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips32_fetch_queue
//  Purpose  : Self-checking bench for mips32_fetch_queue.
//  Revision : 1.0
// ============================================================================
module tb_mips32_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 9;

    logic clk1 = 1'b0;
    logic rst;
    always #5 clk1 = ~clk1;

    mips32_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.master)
    );

    logic [31:0] mem [512];
    always @(posedge clk1) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic h, input logic rdy);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.id_ready       = rdy;
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        halt, ready;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ir, npc;
        int          cnt;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic h, input logic rdy, input logic en,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] ir, input logic [31:0] npc,
                                input int cnt, input logic [31:0] pc);
        vec_t t;
        t.rst = r; t.redir = rv; t.rpc = rpc; t.halt = h; t.ready = rdy;
        t.en = en; t.addr = addr; t.valid = v; t.ir = ir; t.npc = npc;
        t.cnt = cnt; t.pc = pc;
        return t;
    endfunction

    // Behavioural reference: the queue is an SV queue of {ir, npc}.
    typedef struct { logic [31:0] ir, npc; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc, m_ia, m_iw;
    bit          m_inf, m_hlt;

    vec_t        tbl[$];
    logic [31:0] got[$];

    initial begin
        int bad_en;
        for (int i = 0; i < 512; i++) mem[i] = w(i);
        drive(1, 0, 0, 0, 1);
        tick();

        // Sequential fetch, backpressure, redirect with queue + in-flight, halt
        tbl.push_back(mk(1,0,0,    0,1, 0,0,    0,0,     0,    0,0));
        tbl.push_back(mk(0,0,0,    0,1, 1,0,    0,0,     0,    0,0));
        tbl.push_back(mk(0,0,0,    0,1, 1,1,    0,0,     0,    0,1));
        tbl.push_back(mk(0,0,0,    0,1, 1,2,    1,w(0),  1,    1,2));
        tbl.push_back(mk(0,0,0,    0,1, 1,3,    1,w(1),  2,    1,3));
        tbl.push_back(mk(0,0,0,    0,0, 1,4,    1,w(2),  3,    1,4));
        tbl.push_back(mk(0,0,0,    0,0, 1,5,    1,w(2),  3,    2,5));
        tbl.push_back(mk(0,0,0,    0,0, 0,6,    1,w(2),  3,    3,6));
        tbl.push_back(mk(0,0,0,    0,0, 0,6,    1,w(2),  3,    4,6));
        tbl.push_back(mk(0,0,0,    0,1, 0,6,    1,w(2),  3,    4,6));
        tbl.push_back(mk(0,0,0,    0,1, 1,6,    1,w(3),  4,    3,6));
        tbl.push_back(mk(0,0,0,    0,0, 1,7,    1,w(4),  5,    2,7));
        tbl.push_back(mk(0,1,32'h20,0,0, 1,32'h20,1,w(4), 5,    3,8));
        tbl.push_back(mk(0,0,0,    0,0, 1,32'h21,0,0,    0,    0,32'h21));
        tbl.push_back(mk(0,0,0,    0,1, 1,32'h22,1,w(32),32'h21,1,32'h22));
        tbl.push_back(mk(0,0,0,    0,1, 1,32'h23,1,w(33),32'h22,1,32'h23));
        tbl.push_back(mk(0,0,0,    1,1, 0,32'h24,0,0,    0,    1,32'h24));
        tbl.push_back(mk(0,0,0,    1,1, 0,32'h24,0,0,    0,    2,32'h24));
        tbl.push_back(mk(0,0,0,    0,1, 1,32'h24,1,w(34),32'h23,2,32'h24));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].halt, tbl[i].ready);
            @(negedge clk1);
            chk($sformatf("vec%0d.imem_en", i),   32'(bus.imem_en),   32'(tbl[i].en));
            chk($sformatf("vec%0d.imem_addr", i), 32'(bus.imem_addr), tbl[i].addr);
            chk($sformatf("vec%0d.id_valid", i),  32'(bus.id_valid),  32'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d.id_ir", i),  bus.id_ir,  tbl[i].ir);
                chk($sformatf("vec%0d.id_npc", i), bus.id_npc, tbl[i].npc);
            end
            chk($sformatf("vec%0d.q_count", i), 32'(bus.q_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.pc_out", i),  bus.pc_out,       tbl[i].pc);
            tick();
        end

        // HLT at word 3: words 0..3 delivered, fetch stops, redirect resumes
        mem[3] = 32'hFC00_0000;
        drive(1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        bad_en = 0;
        got.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk1);
            if (bus.id_valid) got.push_back(bus.id_ir);
            if (k >= 5 && bus.imem_en) bad_en++;
            tick();
        end
        chk("hlt.delivered_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("hlt.word%0d", k), got[k], mem[k]);
        chk("hlt.imem_en_idle", 32'(bad_en), 32'd0);
        drive(0, 1, 0, 0, 1);
        @(negedge clk1);
        chk("hlt.redir_en",   32'(bus.imem_en),   32'd1);
        chk("hlt.redir_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        @(negedge clk1);
        chk("hlt.resume_valid", 32'(bus.id_valid), 32'd1);
        chk("hlt.resume_ir",    bus.id_ir,         mem[0]);
        chk("hlt.resume_npc",   bus.id_npc,        32'd1);
        tick();
        mem[3] = w(3);

        // Reset mid-stream
        for (int k = 0; k < 7; k++) tick();
        drive(1, 0, 0, 0, 1);
        @(negedge clk1);
        chk("rst.en_during",    32'(bus.imem_en),  32'd0);
        chk("rst.valid_during", 32'(bus.id_valid), 32'd0);
        tick();
        drive(0, 0, 0, 0, 1);
        @(negedge clk1);
        chk("rst.q_count", 32'(bus.q_count),   32'd0);
        chk("rst.pc_out",  bus.pc_out,         32'd0);
        chk("rst.en",      32'(bus.imem_en),   32'd1);
        chk("rst.addr",    32'(bus.imem_addr), 32'd0);
        tick();
        tick();
        @(negedge clk1);
        chk("rst.restart_valid", 32'(bus.id_valid), 32'd1);
        chk("rst.restart_ir",    bus.id_ir,         mem[0]);
        chk("rst.restart_npc",   bus.id_npc,        32'd1);
        tick();

        // Randomized run against the reference model
        for (int i = 0; i < 512; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
        drive(1, 0, 0, 0, 1);
        tick();
        m_q.delete(); m_pc = 0; m_inf = 0; m_hlt = 0; m_ia = 0; m_iw = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, rv, h, rdy, e_en, e_valid;
            logic [31:0] rpc, a;
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            h   = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive(r, rv, rpc, h, rdy);
            @(negedge clk1);
            e_en    = !r && !h && (rv || (!m_hlt && (m_q.size() + int'(m_inf)) < DEPTH));
            e_valid = !r && (m_q.size() != 0) && !h;
            a       = rv ? rpc : m_pc;
            chk("rnd.imem_en",  32'(bus.imem_en),   32'(e_en));
            chk("rnd.imem_addr", 32'(bus.imem_addr), r ? 32'd0 : (a & 32'h1FF));
            chk("rnd.id_valid", 32'(bus.id_valid),  32'(e_valid));
            if (e_valid) begin
                chk("rnd.id_ir",  bus.id_ir,  m_q[0].ir);
                chk("rnd.id_npc", bus.id_npc, m_q[0].npc);
            end
            chk("rnd.q_count", 32'(bus.q_count), 32'(m_q.size()));
            chk("rnd.pc_out",  bus.pc_out,       m_pc);

            if (r) begin
                m_q.delete(); m_pc = 0; m_inf = 0; m_hlt = 0;
            end else begin
                if (rv) begin
                    m_q.delete();
                    m_hlt = 0;
                end else begin
                    if (e_valid && rdy) void'(m_q.pop_front());
                    if (m_inf && !m_hlt) begin
                        ent_t e;
                        e.ir  = m_iw;
                        e.npc = m_ia + 32'd1;
                        m_q.push_back(e);
                        if (m_iw[31:26] == 6'h3F) m_hlt = 1;
                    end
                end
                if (e_en) begin
                    m_iw  = mem[a[8:0]];
                    m_ia  = a;
                    m_pc  = a + 32'd1;
                    m_inf = 1;
                end else begin
                    m_inf = 0;
                    if (rv) m_pc = rpc;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
